// File: rtl/register_file_be_clr.sv
// register_file_be_clr
//   Register file with one write port and two read ports, for the datapath. It
//   provides byte-lane write enables, registered reads with write-through bypass,
//   an optional hardwired-zero register 0 and a hardware clear sweep.
//
// Ports
//   CLK       clock, rising edge
//   rst       asynchronous active-low reset
//   EN        block enable; gates reads and writes but not the clear sweep
//   WR        write request: sel_i1 is the address, Ip1 the data, wr_be the lane mask
//   RD        read request: sel_o1/sel_o2 are the addresses
//   op1/op2   registered read data; rd_valid is set for one cycle after a read
//   clr       starts the clear sweep (level sampled at the clock edge)
//   busy      high while the sweep runs (DEPTH cycles)
module register_file_be_clr #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DEPTH    = 16,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                EN,
  input  logic                WR,
  input  logic [ADDR_W-1:0]   sel_i1,
  input  logic [DATA_W-1:0]   Ip1,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                RD,
  input  logic [ADDR_W-1:0]   sel_o1,
  input  logic [ADDR_W-1:0]   sel_o2,
  output logic [DATA_W-1:0]   op1,
  output logic [DATA_W-1:0]   op2,
  output logic                rd_valid,
  input  logic                clr,
  output logic                busy
);

  localparam int unsigned       NumLanes = DATA_W / 8;
  // One extra bit so that DEPTH == 2**ADDR_W can be represented.
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] op1_q, op2_q;
  logic              rd_valid_q;

  logic [DATA_W-1:0] old_w, merged_w, rd1_val, rd2_val;
  logic              accept, wr_en, rd_en;

  // Address is backed by a real, writable register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthW) && !(ZERO_REG && (a == '0));
  endfunction

  assign accept = EN && !busy_q && !clr;
  assign wr_en  = accept && WR && addr_ok(sel_i1);
  assign rd_en  = accept && RD;

  // Merged write value: new bytes on enabled lanes and old bytes on all other lanes.
  always_comb begin
    old_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_i1 == ADDR_W'(i)) old_w = mem_q[i];
    end
    for (int b = 0; b < NumLanes; b++) begin
      merged_w[8*b +: 8] = wr_be[b] ? Ip1[8*b +: 8] : old_w[8*b +: 8];
    end
  end

  // Read muxes. A write to the same address on this edge is forwarded.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (addr_ok(sel_o1)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_o1 == ADDR_W'(i)) rd1_val = mem_q[i];
      end
      if (wr_en && (sel_o1 == sel_i1)) rd1_val = merged_w;
    end
    if (addr_ok(sel_o2)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_o2 == ADDR_W'(i)) rd2_val = mem_q[i];
      end
      if (wr_en && (sel_o2 == sel_i1)) rd2_val = merged_w;
    end
  end

  // Next state of the array: the sweep zeroes one entry per cycle; otherwise apply the write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (state_q == StClear) begin
        if (cnt_q == ADDR_W'(i)) mem_d[i] = '0;
      end else if (wr_en && (sel_i1 == ADDR_W'(i))) begin
        mem_d[i] = merged_w;
      end
    end
  end

  // Clear-sweep FSM. busy is registered alongside the state.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          if (cnt_q == LastIdx) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage and read registers. op1/op2 keep their values when no read happens.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        op1_q <= rd1_val;
        op2_q <= rd2_val;
      end
    end
  end

  assign op1      = op1_q;
  assign op2      = op2_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule
